dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_pkg.sv | 15 +
 rtl/dm_arbiter_rr_pick.sv | 29 ++
 rtl/dm_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared owner-state encoding and port constants for dm_arbiter
package dm_arbiter_pkg;

  localparam int ST_W     = 2;
  localparam int DMTYPE_W = 3;
  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } own_state_e;

endpackage

// File: rtl/dm_arbiter_rr_pick.sv
// rtl/dm_arbiter_rr_pick.sv - combinational grant selection: lock hold first, then round-robin
module rr_pick
  import dm_arbiter_pkg::*;
(
  input  logic [1:0]      req,
  input  logic            last_gnt,
  input  logic [ST_W-1:0] owner,
  input  logic            lock_ok,
  output logic [1:0]      gnt
);

  always_comb begin
    gnt = 2'b00;
    if (lock_ok && owner == ST_OWN0) begin
      gnt = 2'b01;
    end else if (lock_ok && owner == ST_OWN1) begin
      gnt = 2'b10;
    end else begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // On a tie the port that did not win last time goes next.
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port data-memory arbiter with burst lock and registered read return
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*AW-1:0]       addr,
  input  logic [2*DW-1:0]       wdata,
  input  logic [2*DMTYPE_W-1:0] dmtype,
  input  logic [1:0]            lock,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [DW-1:0]         rdata,
  output logic                  dm_we,
  output logic [AW-1:0]         dm_addr,
  output logic [DW-1:0]         dm_din,
  output logic [DMTYPE_W-1:0]   dm_dmtype,
  input  logic [DW-1:0]         dm_dout
);

  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_BURST);

  own_state_e     state_q, state_d;
  logic           last_gnt_q, last_gnt_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic [1:0]     rvalid_q, rvalid_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  logic           lock_ok;
  logic           same_owner;
  logic [1:0]     pick_gnt;
  logic [1:0]     rd_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= '0;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (gnt[PORT_CPU]) begin
      state_d = ST_OWN0;
    end else if (gnt[PORT_DBG]) begin
      state_d = ST_OWN1;
    end
  end

  // The owner may keep the port only while it still asks with lock and is not starving the other side.
  always_comb begin
    lock_ok = 1'b0;
    case (state_q)
      ST_OWN0: lock_ok = req[PORT_CPU] & lock[PORT_CPU] &
                         (~req[PORT_DBG] | (burst_cnt_q < BURST_MAX));
      ST_OWN1: lock_ok = req[PORT_DBG] & lock[PORT_DBG] &
                         (~req[PORT_CPU] | (burst_cnt_q < BURST_MAX));
      default: lock_ok = 1'b0;
    endcase
  end

  rr_pick u_rr_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .owner    (state_q),
    .lock_ok  (lock_ok),
    .gnt      (pick_gnt)
  );

  assign gnt = reset ? 2'b00 : pick_gnt;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt[PORT_CPU]) begin
      last_gnt_d = 1'b0;
    end else if (gnt[PORT_DBG]) begin
      last_gnt_d = 1'b1;
    end

    same_owner = (gnt[PORT_CPU] && state_q == ST_OWN0) ||
                 (gnt[PORT_DBG] && state_q == ST_OWN1);
    burst_cnt_d = '0;
    if (|gnt) begin
      if (!same_owner) begin
        burst_cnt_d = BCW'(1);
      end else if (burst_cnt_q == BURST_MAX) begin
        burst_cnt_d = burst_cnt_q;
      end else begin
        burst_cnt_d = burst_cnt_q + BCW'(1);
      end
    end
  end

  always_comb begin
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_din    = '0;
    dm_dmtype = '0;
    if (gnt[PORT_CPU]) begin
      dm_we     = we[PORT_CPU];
      dm_addr   = addr[PORT_CPU*AW +: AW];
      dm_din    = wdata[PORT_CPU*DW +: DW];
      dm_dmtype = dmtype[PORT_CPU*DMTYPE_W +: DMTYPE_W];
    end else if (gnt[PORT_DBG]) begin
      dm_we     = we[PORT_DBG];
      dm_addr   = addr[PORT_DBG*AW +: AW];
      dm_din    = wdata[PORT_DBG*DW +: DW];
      dm_dmtype = dmtype[PORT_DBG*DMTYPE_W +: DMTYPE_W];
    end
  end

  always_comb begin
    rd_fire  = gnt & ~we;
    rvalid_d = rd_fire;
    rdata_d  = (|rd_fire) ? dm_dout : rdata_q;
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule
